decode: RTL

Second pipeline stage of the swt16 core, directly downstream of fetch. Registers fetch's PC/instruction pair, splits the instruction into fields and reads the 16-entry register file. Write-back port writes the register file, and write-back values are forwarded to same-cycle reads. Detects load-use hazards, inserts one bubble and presents one ID/EX pipeline register to the execute stage.

---
 rtl/decode_if.sv | 39 +++
 rtl/decode.sv | 123 ++++++++++++
 2 files changed

// File: rtl/decode_if.sv
// Fetch-to-decode and decode-to-execute signal bundle for the swt16 decode stage.
// The slave modport is the decode stage; the master modport is its environment.
interface decode_if #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int REG_WIDTH  = 16
);
  // Fetch side and control
  logic [PC_WIDTH-1:0]   in_pc;
  logic [PMEM_WIDTH-1:0] in_instr;
  logic                  in_flush;
  logic                  in_stall;
  // Write-back port
  logic                  in_wb_en;
  logic [3:0]            in_wb_addr;
  logic [REG_WIDTH-1:0]  in_wb_data;
  // Back-pressure to fetch and ID/EX register to execute
  logic                  out_hold;
  logic                  out_valid;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [PMEM_WIDTH-1:0] out_instr;
  logic [3:0]            out_opcode;
  logic [3:0]            out_rd;
  logic [REG_WIDTH-1:0]  out_rs1_data;
  logic [REG_WIDTH-1:0]  out_rs2_data;
  logic [REG_WIDTH-1:0]  out_imm;

  modport master (
    output in_pc, in_instr, in_flush, in_stall, in_wb_en, in_wb_addr, in_wb_data,
    input  out_hold, out_valid, out_pc, out_instr, out_opcode, out_rd,
           out_rs1_data, out_rs2_data, out_imm
  );

  modport slave (
    input  in_pc, in_instr, in_flush, in_stall, in_wb_en, in_wb_addr, in_wb_data,
    output out_hold, out_valid, out_pc, out_instr, out_opcode, out_rd,
           out_rs1_data, out_rs2_data, out_imm
  );
endinterface

// File: rtl/decode.sv
// swt16 decode stage: captures fetch's PC/instruction, reads the 16-entry
// register file with write-back bypass, inserts one bubble on load-use
// hazards and presents the ID/EX pipeline register to execute.
module decode #(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int REG_WIDTH  = 16
) (
  input logic     clock,
  input logic     reset,
  decode_if.slave bus
);
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_IMM = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_BR  = 4'hB;

  // Register file and ID/EX state
  logic [REG_WIDTH-1:0]  rf_q [16];
  logic [REG_WIDTH-1:0]  rf_d [16];
  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PMEM_WIDTH-1:0] instr_q, instr_d;
  logic [REG_WIDTH-1:0]  rs1_q, rs1_d;
  logic [REG_WIDTH-1:0]  rs2_q, rs2_d;

  logic [3:0]           in_op, rs1_addr, rs2_addr;
  logic [REG_WIDTH-1:0] rs1_rd, rs2_rd;
  logic                 in_reads_rs2;
  logic                 hazard;
  logic                 hold;

  assign in_op    = bus.in_instr[15:12];
  assign rs1_addr = bus.in_instr[7:4];
  assign rs2_addr = bus.in_instr[3:0];

  // Register file write: r0 is hard-wired to zero, so writes to it are dropped
  always_comb begin
    rf_d = rf_q;
    if (bus.in_wb_en && bus.in_wb_addr != 4'd0) begin
      rf_d[bus.in_wb_addr] = bus.in_wb_data;
    end
  end

  // Source reads with same-cycle write-back forwarding
  always_comb begin
    rs1_rd = (rs1_addr == 4'd0) ? '0 : rf_q[rs1_addr];
    rs2_rd = (rs2_addr == 4'd0) ? '0 : rf_q[rs2_addr];
    if (bus.in_wb_en && bus.in_wb_addr != 4'd0 && bus.in_wb_addr == rs1_addr) begin
      rs1_rd = bus.in_wb_data;
    end
    if (bus.in_wb_en && bus.in_wb_addr != 4'd0 && bus.in_wb_addr == rs2_addr) begin
      rs2_rd = bus.in_wb_data;
    end
  end

  // Load-use detection: a load in ID/EX whose destination the incoming
  // instruction sources; rs2 only counts for formats that actually read it
  always_comb begin
    in_reads_rs2 = !(in_op == OP_NOP || in_op == OP_IMM || in_op == OP_BR);
    hazard = valid_q && (instr_q[15:12] == OP_LD) && (instr_q[11:8] != 4'd0) &&
             ((instr_q[11:8] == rs1_addr) || (in_reads_rs2 && instr_q[11:8] == rs2_addr));
  end

  // ID/EX next state: stall holds, flush or hazard loads a bubble, else capture
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    hold    = 1'b0;
    if (bus.in_stall) begin
      hold = 1'b1;
    end else if (bus.in_flush || hazard) begin
      hold    = !bus.in_flush;
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = '0;
      rs1_d   = '0;
      rs2_d   = '0;
    end else begin
      valid_d = (bus.in_instr != '0);
      pc_d    = bus.in_pc;
      instr_d = bus.in_instr;
      rs1_d   = rs1_rd;
      rs2_d   = rs2_rd;
    end
  end

  // State registers; reset clears the pipeline register and the register file
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign bus.out_hold     = hold;
  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_instr    = instr_q;
  assign bus.out_opcode   = instr_q[15:12];
  assign bus.out_rd       = instr_q[11:8];
  assign bus.out_rs1_data = rs1_q;
  assign bus.out_rs2_data = rs2_q;
  assign bus.out_imm      = {{(REG_WIDTH-8){instr_q[7]}}, instr_q[7:0]};
endmodule
